// File: rtl/barvinn_run_monitor_pkg.sv
// Shared types and helpers for the BARVINN run monitor.
// Holds the run-controller state encoding and the hart-index width rule.
package barvinn_mon_pkg;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_HALT = 2'd2
  } mon_state_e;

  // Width of a hart index; a single hart still gets a 1-bit id.
  function automatic int hart_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/barvinn_run_monitor_stall.sv
// Per-hart stall watchdog: counts consecutive cycles without progress
// while the hart is enabled and not yet done, and latches a sticky flag.
module hart_stall_counter #(
  parameter int CNT_W        = 32,
  parameter int STALL_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic active,
  input  logic done,
  output logic stall
);

  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYCLES);
  localparam bit               STALL_EN  = (STALL_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;

  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (clr) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else if (en && !done) begin
      if (active) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (STALL_EN && (cnt_d >= STALL_LIM)) begin
        stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;

endmodule

// File: rtl/barvinn_run_monitor.sv
// Run controller/watchdog for BARVINN multi-hart runs: tracks per-hart
// done/fail/stall and ends each run as pass, fail or timeout.
module barvinn_run_monitor
  import barvinn_mon_pkg::*;
#(
  parameter  int NUM_HARTS      = 8,
  parameter  int CNT_W          = 32,
  parameter  int TIMEOUT_CYCLES = 10000,
  parameter  int STALL_CYCLES   = 1024,
  localparam int HART_ID_W      = hart_id_w(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [NUM_HARTS-1:0] hart_en_i,
  input  logic [CNT_W-1:0]     timeout_cfg_i,
  input  logic [NUM_HARTS-1:0] hart_done_i,
  input  logic [NUM_HARTS-1:0] hart_fail_i,
  input  logic [NUM_HARTS-1:0] hart_active_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     cycle_cnt_o,
  output logic [NUM_HARTS-1:0] done_mask_o,
  output logic [NUM_HARTS-1:0] fail_mask_o,
  output logic [NUM_HARTS-1:0] stall_mask_o,
  output logic [HART_ID_W-1:0] first_fail_o
);

  localparam logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  mon_state_e           state_q, state_d;
  logic [NUM_HARTS-1:0] en_q, en_d;
  logic [NUM_HARTS-1:0] done_q, done_d;
  logic [NUM_HARTS-1:0] fail_q, fail_d;
  logic [CNT_W-1:0]     limit_q, limit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HART_ID_W-1:0] first_fail_q, first_fail_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 done_pulse_q, done_pulse_d;

  logic [CNT_W-1:0]     cnt_inc;
  logic [NUM_HARTS-1:0] done_nx, fail_nx;
  logic [NUM_HARTS-1:0] stall_mask;
  logic [NUM_HARTS-1:0] stall_en;
  logic [HART_ID_W-1:0] fail_idx;
  logic                 fail_found;
  logic                 complete;
  logic                 limit_hit;
  logic                 arm;
  logic                 stall_clr;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign done_nx   = done_q | ((hart_done_i | hart_fail_i) & en_q);
  assign fail_nx   = fail_q | (hart_fail_i & en_q);
  assign complete  = &(done_nx | ~en_q);
  assign limit_hit = (cnt_inc >= limit_q);
  assign arm       = start_i && !clear_i && (state_q != MON_RUN);
  assign stall_clr = clear_i || arm;
  assign stall_en  = {NUM_HARTS{state_q == MON_RUN}} & en_q;

  // Only consulted while fail_q is still zero, so the lowest set bit of
  // fail_nx is the lowest hart among those failing in the earliest cycle.
  always_comb begin
    fail_idx   = '0;
    fail_found = 1'b0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (fail_nx[i] && !fail_found) begin
        fail_idx   = HART_ID_W'(i);
        fail_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    done_d       = done_q;
    fail_d       = fail_q;
    limit_d      = limit_q;
    cnt_d        = cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    done_pulse_d = 1'b0;

    if (clear_i) begin
      state_d      = MON_IDLE;
      en_d         = '0;
      done_d       = '0;
      fail_d       = '0;
      limit_d      = '0;
      cnt_d        = '0;
      first_fail_d = '0;
      pass_d       = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        MON_IDLE, MON_HALT: begin
          if (start_i) begin
            state_d      = MON_RUN;
            en_d         = hart_en_i;
            limit_d      = (timeout_cfg_i == '0) ? DEFAULT_LIMIT : timeout_cfg_i;
            done_d       = '0;
            fail_d       = '0;
            cnt_d        = '0;
            first_fail_d = '0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
          end
        end
        MON_RUN: begin
          cnt_d  = cnt_inc;
          done_d = done_nx;
          fail_d = fail_nx;
          if ((fail_q == '0) && (fail_nx != '0)) begin
            first_fail_d = fail_idx;
          end
          // Completion is checked first so it wins over a same-cycle timeout.
          if (complete) begin
            state_d      = MON_HALT;
            pass_d       = (fail_nx == '0);
            done_pulse_d = 1'b1;
          end else if (limit_hit) begin
            state_d      = MON_HALT;
            timeout_d    = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
        default: state_d = MON_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= MON_IDLE;
      en_q         <= '0;
      done_q       <= '0;
      fail_q       <= '0;
      limit_q      <= '0;
      cnt_q        <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      limit_q      <= limit_d;
      cnt_q        <= cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_stall
    hart_stall_counter #(
      .CNT_W       (CNT_W),
      .STALL_CYCLES(STALL_CYCLES)
    ) u_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stall_clr),
      .en    (stall_en[g]),
      .active(hart_active_i[g]),
      .done  (done_q[g]),
      .stall (stall_mask[g])
    );
  end

  assign busy_o       = (state_q == MON_RUN);
  assign done_o       = done_pulse_q;
  assign pass_o       = pass_q;
  assign timeout_o    = timeout_q;
  assign cycle_cnt_o  = cnt_q;
  assign done_mask_o  = done_q;
  assign fail_mask_o  = fail_q;
  assign stall_mask_o = stall_mask;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_barvinn_run_monitor.sv
// Self-checking bench for barvinn_run_monitor: directed scenarios plus
// randomized runs against a run-level behavioural model.
module tb_barvinn_run_monitor;

  localparam int NH      = 8;
  localparam int CW      = 32;
  localparam int TO_DEF  = 200;
  localparam int STALL_C = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, clear_i;
  logic [NH-1:0] hart_en_i, hart_done_i, hart_fail_i, hart_active_i;
  logic [CW-1:0] timeout_cfg_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [NH-1:0] done_mask_o, fail_mask_o, stall_mask_o;
  logic [2:0]    first_fail_o;

  barvinn_run_monitor #(
    .NUM_HARTS     (NH),
    .CNT_W         (CW),
    .TIMEOUT_CYCLES(TO_DEF),
    .STALL_CYCLES  (STALL_C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .hart_en_i    (hart_en_i),
    .timeout_cfg_i(timeout_cfg_i),
    .hart_done_i  (hart_done_i),
    .hart_fail_i  (hart_fail_i),
    .hart_active_i(hart_active_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o),
    .cycle_cnt_o  (cycle_cnt_o),
    .done_mask_o  (done_mask_o),
    .fail_mask_o  (fail_mask_o),
    .stall_mask_o (stall_mask_o),
    .first_fail_o (first_fail_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Run-level model: a run is "busy" until every enabled hart has reported
  // done/fail or the cycle budget is spent; idle[] counts silent cycles.
  bit          m_busy, m_pulse, m_pass, m_to;
  int unsigned m_cnt, m_lim;
  logic [NH-1:0] m_en, m_dm, m_fm, m_sm, m_nf;
  int          m_ff;
  int          idle [NH];

  function automatic void model_zero();
    m_busy = 0; m_pass = 0; m_to = 0; m_cnt = 0; m_lim = 0;
    m_en = '0; m_dm = '0; m_fm = '0; m_sm = '0; m_ff = 0;
    for (int h = 0; h < NH; h++) idle[h] = 0;
  endfunction

  always @(posedge clk) begin
    m_pulse = 0;
    if (!rst_n || clear_i) begin
      model_zero();
    end else if (!m_busy) begin
      if (start_i) begin
        model_zero();
        m_busy = 1;
        m_en   = hart_en_i;
        m_lim  = (timeout_cfg_i == 0) ? TO_DEF : timeout_cfg_i;
      end
    end else begin
      m_cnt++;
      for (int h = 0; h < NH; h++) begin
        if (m_en[h] && !m_dm[h]) begin
          idle[h] = hart_active_i[h] ? 0 : idle[h] + 1;
          if (idle[h] >= STALL_C) m_sm[h] = 1'b1;
        end
      end
      m_nf = hart_fail_i & m_en;
      if (m_fm == 0 && m_nf != 0) begin
        m_ff = -1;
        for (int h = NH - 1; h >= 0; h--) if (m_nf[h]) m_ff = h;
      end
      m_fm = m_fm | m_nf;
      m_dm = m_dm | ((hart_done_i | hart_fail_i) & m_en);
      if (m_dm == m_en) begin
        m_busy = 0; m_pass = (m_fm == 0); m_pulse = 1;
      end else if (m_cnt >= m_lim) begin
        m_busy = 0; m_to = 1; m_pulse = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy",       32'(busy_o),       32'(m_busy));
      check("done_pulse", 32'(done_o),       32'(m_pulse));
      check("pass",       32'(pass_o),       32'(m_pass));
      check("timeout",    32'(timeout_o),    32'(m_to));
      check("cycle_cnt",  cycle_cnt_o,       m_cnt);
      check("done_mask",  32'(done_mask_o),  32'(m_dm));
      check("fail_mask",  32'(fail_mask_o),  32'(m_fm));
      check("stall_mask", 32'(stall_mask_o), 32'(m_sm));
      check("first_fail", 32'(first_fail_o), 32'(m_ff));
    end
  end

  // Per-hart schedule for a run (cycle numbers are 1-based RUN cycles, 0 = never).
  int done_at [NH];
  int fail_at [NH];
  bit lvl     [NH];
  int act_mode[NH];
  int act_once[NH];

  task automatic clr_sched();
    for (int h = 0; h < NH; h++) begin
      done_at[h] = 0; fail_at[h] = 0; lvl[h] = 0; act_mode[h] = 0; act_once[h] = 0;
    end
  endtask

  task automatic run_sched(input logic [NH-1:0] en, input logic [CW-1:0] cfg,
                           input int maxc, input bit rnd_ctl);
    logic [NH-1:0] d, f, a;
    @(negedge clk);
    start_i = 1; clear_i = 0; hart_en_i = en; timeout_cfg_i = cfg;
    hart_done_i = '0; hart_fail_i = '0; hart_active_i = '0;
    @(negedge clk);
    start_i = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (!busy_o) break;
      for (int h = 0; h < NH; h++) begin
        d[h] = (c == done_at[h]) || (lvl[h] && done_at[h] != 0 && c > done_at[h]);
        f[h] = (c == fail_at[h]);
        case (act_mode[h])
          0:       a[h] = 1'b1;
          1:       a[h] = ($urandom % 4) != 0;
          default: a[h] = (c == act_once[h]);
        endcase
      end
      hart_done_i = d; hart_fail_i = f; hart_active_i = a;
      if (rnd_ctl) begin
        start_i       = ($urandom % 8) == 0;
        clear_i       = ($urandom % 300) == 0;
        hart_en_i     = NH'($urandom);
        timeout_cfg_i = $urandom;
      end
      @(negedge clk);
    end
    start_i = 0; clear_i = 0;
    hart_done_i = '0; hart_fail_i = '0; hart_active_i = '0;
    check("run_bound", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start_i = 0; clear_i = 0; hart_en_i = '0; timeout_cfg_i = '0;
    hart_done_i = '0; hart_fail_i = '0; hart_active_i = '0;
    clr_sched();
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cnt",  cycle_cnt_o, 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    rst_n = 1;

    // 1: all harts, hart k done at cycle 10+k
    clr_sched();
    for (int h = 0; h < NH; h++) done_at[h] = 10 + h;
    run_sched(8'hFF, 32'd0, 100, 0);
    check("t1_done_o", 32'(done_o), 32'd1);
    check("t1_pass",   32'(pass_o), 32'd1);
    check("t1_cnt",    cycle_cnt_o, 32'd17);
    check("t1_dmask",  32'(done_mask_o), 32'hFF);

    // 2: timeout with only harts 0,1 finishing
    clr_sched();
    done_at[0] = 5; done_at[1] = 8;
    run_sched(8'h0F, 32'd50, 100, 0);
    check("t2_timeout", 32'(timeout_o), 32'd1);
    check("t2_pass",    32'(pass_o), 32'd0);
    check("t2_cnt",     cycle_cnt_o, 32'd50);
    check("t2_dmask",   32'(done_mask_o), 32'h03);

    // 3: harts 5 and 2 fail together at cycle 20
    clr_sched();
    for (int h = 0; h < NH; h++) done_at[h] = 22 + h;
    done_at[2] = 0; done_at[5] = 0; fail_at[2] = 20; fail_at[5] = 20;
    run_sched(8'hFF, 32'd0, 100, 0);
    check("t3_pass",  32'(pass_o), 32'd0);
    check("t3_fmask", 32'(fail_mask_o), 32'h24);
    check("t3_first", 32'(first_fail_o), 32'd2);
    check("t3_cnt",   cycle_cnt_o, 32'd29);

    // 4: completion and limit in the same cycle
    clr_sched();
    for (int h = 0; h < NH; h++) done_at[h] = 10;
    done_at[0] = 40;
    run_sched(8'hFF, 32'd40, 100, 0);
    check("t4_pass",    32'(pass_o), 32'd1);
    check("t4_timeout", 32'(timeout_o), 32'd0);
    check("t4_cnt",     cycle_cnt_o, 32'd40);

    // 5: hart 3 active once then silent -> stall, run still passes
    clr_sched();
    for (int h = 0; h < NH; h++) done_at[h] = 25;
    done_at[3] = 30; act_mode[3] = 2; act_once[3] = 2;
    run_sched(8'hFF, 32'd0, 100, 0);
    check("t5_stall", 32'(stall_mask_o), 32'h08);
    check("t5_pass",  32'(pass_o), 32'd1);

    // default limit when timeout_cfg_i is zero
    clr_sched();
    run_sched(8'h01, 32'd0, 250, 0);
    check("to_def_timeout", 32'(timeout_o), 32'd1);
    check("to_def_cnt",     cycle_cnt_o, 32'(TO_DEF));

    // 6: empty enable, re-arm from HALT, reset mid-run, clear beats start
    clr_sched();
    run_sched(8'h00, 32'd0, 10, 0);
    check("t6_en0_pass", 32'(pass_o), 32'd1);
    check("t6_en0_cnt",  cycle_cnt_o, 32'd1);
    start_i = 1; hart_en_i = 8'h01; timeout_cfg_i = 32'd100;
    @(negedge clk);
    start_i = 0;
    @(negedge clk);
    check("t6_rearm_busy", 32'(busy_o), 32'd1);
    check("t6_rearm_cnt",  cycle_cnt_o, 32'd1);
    rst_n = 0;
    @(negedge clk);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_rst_cnt",  cycle_cnt_o, 32'd0);
    rst_n = 1;
    run_sched(8'h00, 32'd0, 10, 0);
    start_i = 1; clear_i = 1;
    @(negedge clk);
    start_i = 0; clear_i = 0;
    check("t6_clr_busy", 32'(busy_o), 32'd0);
    check("t6_clr_pass", 32'(pass_o), 32'd0);
    check("t6_clr_cnt",  cycle_cnt_o, 32'd0);

    // randomized runs, with garbage on hart inputs between runs
    for (int r = 0; r < 40; r++) begin
      for (int h = 0; h < NH; h++) begin
        done_at[h]  = ($urandom % 3 == 0) ? 0 : 1 + int'($urandom % 120);
        fail_at[h]  = ($urandom % 6 == 0) ? 1 + int'($urandom % 120) : 0;
        lvl[h]      = $urandom % 2;
        act_mode[h] = int'($urandom % 3);
        act_once[h] = 1 + int'($urandom % 30);
      end
      run_sched(NH'($urandom), ($urandom % 4 == 0) ? 32'd0 : 32'(20 + $urandom % 100),
                260, (r % 3) == 0);
      repeat ($urandom % 4) begin
        hart_done_i = NH'($urandom); hart_fail_i = NH'($urandom); hart_active_i = NH'($urandom);
        @(negedge clk);
      end
      hart_done_i = '0; hart_fail_i = '0; hart_active_i = '0;
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
